// File: rtl/shift_reg_universal_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// the counter-width helper and a small mode decoder used by the top level.
package shift_pkg;

  // Operation select codes carried on the 3-bit mode input.
  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHR   = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_ROR   = 3'd3;
  localparam logic [2:0] MODE_ROL   = 3'd4;
  localparam logic [2:0] MODE_LOAD  = 3'd5;
  localparam logic [2:0] MODE_CLEAR = 3'd6;
  localparam logic [2:0] MODE_RSVD  = 3'd7;

  // Classification of a mode for the word counter.
  //   shift   : the cycle moves data by one position (SHR/SHL/ROR/ROL)
  //   restart : the cycle begins a fresh word (LOAD/CLEAR)
  typedef struct packed {
    logic shift;
    logic restart;
  } mode_class_t;

  // Width of the shifts-in-word counter. A 2-bit register still needs one
  // counter bit, so the result never drops below 1.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

  // Map an operation code onto its counter classification. HOLD and the
  // reserved code fall through to "neither", which leaves the count alone.
  function automatic mode_class_t classify_mode(input logic [2:0] mode);
    mode_class_t c;
    c.shift   = 1'b0;
    c.restart = 1'b0;
    case (mode)
      MODE_SHR,
      MODE_SHL,
      MODE_ROR,
      MODE_ROL:   c.shift   = 1'b1;
      MODE_LOAD,
      MODE_CLEAR: c.restart = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_reg_universal_word_counter.sv
// Counts shifts within the current word and raises a one-cycle strobe on
// the cycle after the WIDTH-th shift. LOAD/CLEAR restart the word.
module shift_word_counter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             shift,
  input  logic             restart,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  // Count value on which the next shift completes a word.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  // Next count and strobe. The strobe defaults low so it lasts exactly one
  // cycle; restart wins over shift although both cannot come from one mode.
  always_comb begin
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    if (en) begin
      if (restart) begin
        cnt_nxt = '0;
      end else if (shift) begin
        if (shift_cnt == LAST_CNT) begin
          cnt_nxt  = '0;
          done_nxt = 1'b1;
        end else begin
          cnt_nxt = shift_cnt + 1'b1;
        end
      end
    end
  end

  // Counter and strobe registers; reset clears both immediately so a
  // partially shifted word never produces a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      shift_cnt <= cnt_nxt;
      word_done <= done_nxt;
    end
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Parametrised universal shift register: shift left/right with serial
// inputs, rotate either way, parallel load, synchronous clear and a clock
// enable. A sub-module tracks shifts per word and strobes word_done.
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter  int               WIDTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] q_nxt;
  mode_class_t      mode_class;

  // Mode mux: next register contents. Disabled cycles, HOLD and the
  // reserved code all keep q; CLEAR writes zero rather than RESET_VAL.
  always_comb begin
    q_nxt = q;
    if (en) begin
      case (mode)
        MODE_SHR:   q_nxt = {sin_r, q[WIDTH-1:1]};
        MODE_SHL:   q_nxt = {q[WIDTH-2:0], sin_l};
        MODE_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
        MODE_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_LOAD:  q_nxt = pdata_in;
        MODE_CLEAR: q_nxt = '0;
        default:    q_nxt = q;
      endcase
    end
  end

  // Data register with asynchronous reset to RESET_VAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  // Serial outputs are the two end bits of the register.
  always_comb begin
    sout_r = q[0];
    sout_l = q[WIDTH-1];
  end

  // Classify the requested operation for the word counter.
  always_comb begin
    mode_class = classify_mode(mode);
  end

  shift_word_counter #(
    .WIDTH (WIDTH)
  ) u_word_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .shift     (mode_class.shift),
    .restart   (mode_class.restart),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal: a 4-bit instance (RESET_VAL 4'b1010) and an
// 8-bit instance (RESET_VAL 8'h3C) share clock and reset. A reference model
// computes expected contents with plain arithmetic on integers.
module tb_shift_reg_universal;

  localparam logic [2:0] M_HOLD = 3'd0, M_SHR = 3'd1, M_SHL = 3'd2, M_ROR = 3'd3;
  localparam logic [2:0] M_ROL = 3'd4, M_LOAD = 3'd5, M_CLEAR = 3'd6, M_RSVD = 3'd7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       en4 = 1'b0, sr4 = 1'b0, sl4 = 1'b0;
  logic [2:0] mode4 = 3'd0;
  logic [3:0] pd4 = 4'h0;
  logic [3:0] q4;
  logic       sout_r4, sout_l4, done4;
  logic [1:0] cnt4;

  logic       en8 = 1'b0, sr8 = 1'b0, sl8 = 1'b0;
  logic [2:0] mode8 = 3'd0;
  logic [7:0] pd8 = 8'h00;
  logic [7:0] q8;
  logic       sout_r8, sout_l8, done8;
  logic [2:0] cnt8;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state, index 0 = 4-bit instance, 1 = 8-bit instance.
  logic [7:0] mq[2];
  int         mcnt[2];
  logic       mdone[2];
  int         wid[2] = '{4, 8};

  shift_reg_universal #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en4), .mode(mode4), .sin_r(sr4), .sin_l(sl4),
    .pdata_in(pd4), .q(q4), .sout_r(sout_r4), .sout_l(sout_l4),
    .shift_cnt(cnt4), .word_done(done4)
  );

  shift_reg_universal #(.WIDTH(8), .RESET_VAL(8'h3C)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en8), .mode(mode8), .sin_r(sr8), .sin_l(sl8),
    .pdata_in(pd8), .q(q8), .sout_r(sout_r8), .sout_l(sout_l8),
    .shift_cnt(cnt8), .word_done(done8)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic model_reset();
    mq[0] = 8'h0A; mq[1] = 8'h3C;
    mcnt[0] = 0; mcnt[1] = 0;
    mdone[0] = 1'b0; mdone[1] = 1'b0;
  endtask

  // One clock of the reference model, written from the operation rules.
  task automatic model_update(input int i, input logic e, input logic [2:0] md,
                              input logic sr, input logic sl, input logic [7:0] pd);
    int   w;
    int   v;
    int   top;
    int   mask;
    w    = wid[i];
    v    = int'(mq[i]);
    top  = 1 << (w - 1);
    mask = (1 << w) - 1;
    mdone[i] = 1'b0;
    if (e) begin
      case (md)
        M_SHR:   v = (v / 2) + (sr ? top : 0);
        M_SHL:   v = ((v * 2) + (sl ? 1 : 0)) & mask;
        M_ROR:   v = (v / 2) + (((v % 2) == 1) ? top : 0);
        M_ROL:   v = ((v * 2) & mask) + ((v >= top) ? 1 : 0);
        M_LOAD:  v = int'(pd) & mask;
        M_CLEAR: v = 0;
        default: ;
      endcase
      if (md >= M_SHR && md <= M_ROL) begin
        mcnt[i] = mcnt[i] + 1;
        if (mcnt[i] == w) begin
          mcnt[i]  = 0;
          mdone[i] = 1'b1;
        end
      end else if (md == M_LOAD || md == M_CLEAR) begin
        mcnt[i] = 0;
      end
    end
    mq[i] = 8'(v);
  endtask

  // Drive one cycle on the selected instance (the other is disabled),
  // advance the model, then sample point is 1 time unit after the edge.
  task automatic step(input int sel, input logic e, input logic [2:0] md,
                      input logic sr, input logic sl, input logic [7:0] pd);
    if (sel == 0) begin
      en4 = e; mode4 = md; sr4 = sr; sl4 = sl; pd4 = pd[3:0]; en8 = 1'b0;
    end else begin
      en8 = e; mode8 = md; sr8 = sr; sl8 = sl; pd8 = pd; en4 = 1'b0;
    end
    model_update(0, (sel == 0) ? e : 1'b0, md, sr, sl, pd);
    model_update(1, (sel == 1) ? e : 1'b0, md, sr, sl, pd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // In reset from time 0; sample before any release.
    #12;
    total_cnt++; if (q4 !== 4'hA) $display("FAIL reset_q4: got %h want a", q4); else pass_cnt++;
    total_cnt++; if (cnt4 !== 2'd0) $display("FAIL reset_cnt4: got %0d want 0", cnt4); else pass_cnt++;
    total_cnt++; if (q8 !== 8'h3C) $display("FAIL reset_q8: got %h want 3c", q8); else pass_cnt++;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    // Fill a word so the strobe is high, then reset mid-cycle.
    for (int k = 0; k < 4; k++) step(0, 1'b1, M_SHR, 1'b1, 1'b0, 8'h00);
    total_cnt++; if (done4 !== 1'b1) $display("FAIL reset_pre_done: got %b want 1", done4); else pass_cnt++;
    en4 = 1'b0; en8 = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (q4 !== 4'hA) $display("FAIL reset_mid_q4: got %h want a", q4); else pass_cnt++;
    total_cnt++; if (cnt4 !== 2'd0) $display("FAIL reset_mid_cnt4: got %0d want 0", cnt4); else pass_cnt++;
    total_cnt++; if (done4 !== 1'b0) $display("FAIL reset_mid_done4: got %b want 0", done4); else pass_cnt++;
    #1;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    total_cnt++; if (q4 !== 4'hA || done4 !== 1'b0) $display("FAIL reset_release: got q=%h done=%b want q=a done=0", q4, done4); else pass_cnt++;
  endtask

  task automatic test_siso();
    logic [3:0] exp_q[4];
    logic       sin_s[4];
    logic [3:0] eq;
    exp_q = '{4'hD, 4'h6, 4'hB, 4'hD};
    sin_s = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      step(0, 1'b1, M_SHR, sin_s[k], 1'b0, 8'h00);
      eq = exp_q[k];
      total_cnt++; if (q4 !== eq) $display("FAIL siso_q edge%0d: got %h want %h", k + 1, q4, eq); else pass_cnt++;
      total_cnt++; if (done4 !== (k == 3)) $display("FAIL siso_done edge%0d: got %b want %b", k + 1, done4, (k == 3)); else pass_cnt++;
      total_cnt++; if (sout_l4 !== eq[3]) $display("FAIL siso_sout_l edge%0d: got %b want %b", k + 1, sout_l4, eq[3]); else pass_cnt++;
    end
    total_cnt++; if (sout_r4 !== sin_s[0]) $display("FAIL siso_delay0: got %b want %b", sout_r4, sin_s[0]); else pass_cnt++;
    step(0, 1'b0, M_SHR, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (done4 !== 1'b0) $display("FAIL siso_done_clear: got %b want 0", done4); else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      step(0, 1'b1, M_SHR, 1'b0, 1'b0, 8'h00);
      total_cnt++; if (sout_r4 !== sin_s[k]) $display("FAIL siso_delay%0d: got %b want %b", k, sout_r4, sin_s[k]); else pass_cnt++;
    end
  endtask

  task automatic test_piso();
    logic [7:0] v;
    v = 8'hA5;
    step(1, 1'b1, M_LOAD, 1'b0, 1'b0, 8'hA5);
    total_cnt++; if (q8 !== 8'hA5) $display("FAIL piso_load: got %h want a5", q8); else pass_cnt++;
    total_cnt++; if (cnt8 !== 3'd0) $display("FAIL piso_cnt: got %0d want 0", cnt8); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      total_cnt++; if (sout_r8 !== v[k]) $display("FAIL piso_bit%0d: got %b want %b", k, sout_r8, v[k]); else pass_cnt++;
      step(1, 1'b1, M_SHR, 1'b0, 1'b0, 8'h00);
      total_cnt++; if (done8 !== (k == 7)) $display("FAIL piso_done shift%0d: got %b want %b", k + 1, done8, (k == 7)); else pass_cnt++;
    end
    total_cnt++; if (q8 !== 8'h00) $display("FAIL piso_empty: got %h want 00", q8); else pass_cnt++;
    step(1, 1'b1, M_HOLD, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (done8 !== 1'b0) $display("FAIL piso_single_done: got %b want 0", done8); else pass_cnt++;
  endtask

  task automatic test_rotate();
    step(1, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h81);
    step(1, 1'b1, M_ROL, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (q8 !== 8'h03) $display("FAIL rot_rol: got %h want 03", q8); else pass_cnt++;
    step(1, 1'b1, M_ROR, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (q8 !== 8'h81) $display("FAIL rot_ror1: got %h want 81", q8); else pass_cnt++;
    step(1, 1'b1, M_ROR, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (q8 !== 8'hC0) $display("FAIL rot_ror2: got %h want c0", q8); else pass_cnt++;
    total_cnt++; if (cnt8 !== 3'd3) $display("FAIL rot_cnt: got %0d want 3", cnt8); else pass_cnt++;
  endtask

  task automatic test_enable_hold();
    step(0, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h09);
    step(0, 1'b1, M_SHL, 1'b0, 1'b1, 8'h00);
    step(0, 1'b1, M_SHL, 1'b0, 1'b1, 8'h00);
    total_cnt++; if (q4 !== 4'h7) $display("FAIL hold_pre: got %h want 7", q4); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b0, M_SHL, 1'b1, 1'b1, 8'h0F);
      total_cnt++;
      if (q4 !== 4'h7 || cnt4 !== 2'd2 || done4 !== 1'b0)
        $display("FAIL hold_en0 cyc%0d: got q=%h cnt=%0d done=%b want q=7 cnt=2 done=0", k, q4, cnt4, done4);
      else pass_cnt++;
    end
    step(0, 1'b1, M_RSVD, 1'b1, 1'b1, 8'h0F);
    total_cnt++;
    if (q4 !== 4'h7 || cnt4 !== 2'd2 || done4 !== 1'b0)
      $display("FAIL hold_mode7: got q=%h cnt=%0d done=%b want q=7 cnt=2 done=0", q4, cnt4, done4);
    else pass_cnt++;
    step(0, 1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (q4 !== 4'hE || done4 !== 1'b0) $display("FAIL hold_shift3: got q=%h done=%b want q=e done=0", q4, done4); else pass_cnt++;
    step(0, 1'b1, M_SHL, 1'b0, 1'b0, 8'h00);
    total_cnt++;
    if (q4 !== 4'hC || done4 !== 1'b1 || cnt4 !== 2'd0)
      $display("FAIL hold_shift4: got q=%h done=%b cnt=%0d want q=c done=1 cnt=0", q4, done4, cnt4);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    step(0, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step(0, 1'b1, M_SHR, 1'b1, 1'b0, 8'h00);
    total_cnt++; if (cnt4 !== 2'd3) $display("FAIL restart_pre_cnt: got %0d want 3", cnt4); else pass_cnt++;
    step(0, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h0F);
    total_cnt++;
    if (q4 !== 4'hF || cnt4 !== 2'd0 || done4 !== 1'b0)
      $display("FAIL restart_load: got q=%h cnt=%0d done=%b want q=f cnt=0 done=0", q4, cnt4, done4);
    else pass_cnt++;
    step(0, 1'b1, M_SHR, 1'b1, 1'b0, 8'h00);
    total_cnt++; if (done4 !== 1'b0 || cnt4 !== 2'd1) $display("FAIL restart_noword: got done=%b cnt=%0d want done=0 cnt=1", done4, cnt4); else pass_cnt++;
    step(0, 1'b1, M_CLEAR, 1'b0, 1'b0, 8'h00);
    total_cnt++;
    if (q4 !== 4'h0 || cnt4 !== 2'd0 || done4 !== 1'b0)
      $display("FAIL restart_clear: got q=%h cnt=%0d done=%b want q=0 cnt=0 done=0", q4, cnt4, done4);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    step(1, 1'b1, M_LOAD, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k <= 24; k++) begin
      step(1, 1'b1, M_SHR, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
      if (done8 === 1'b1) pulses++;
      total_cnt++;
      if (done8 !== ((k % 8) == 0)) $display("FAIL b2b_done shift%0d: got %b want %b", k, done8, ((k % 8) == 0));
      else pass_cnt++;
    end
    total_cnt++; if (pulses != 3) $display("FAIL b2b_pulses: got %0d want 3", pulses); else pass_cnt++;
  endtask

  task automatic test_random();
    int         sel;
    logic       e;
    logic [2:0] md;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 1);
      e   = ($urandom_range(0, 7) != 0);
      md  = 3'($urandom_range(0, 7));
      step(sel, e, md, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      total_cnt++;
      if (q4 !== mq[0][3:0] || cnt4 !== 2'(mcnt[0]) || done4 !== mdone[0] ||
          sout_r4 !== mq[0][0] || sout_l4 !== mq[0][3])
        $display("FAIL rand4 n%0d: got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b",
                 n, q4, cnt4, done4, mq[0][3:0], mcnt[0], mdone[0]);
      else pass_cnt++;
      total_cnt++;
      if (q8 !== mq[1] || cnt8 !== 3'(mcnt[1]) || done8 !== mdone[1] ||
          sout_r8 !== mq[1][0] || sout_l8 !== mq[1][7])
        $display("FAIL rand8 n%0d: got q=%h cnt=%0d done=%b want q=%h cnt=%0d done=%b",
                 n, q8, cnt8, done8, mq[1], mcnt[1], mdone[1]);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_siso();
    test_piso();
    test_rotate();
    test_enable_hold();
    test_restart();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
